thermometer_decoder: RTL and testbench
======================================

# thermometer_decoder

Registered binary-to-thermometer decoder for the TDC datapath, the inverse of the thermometer encoder. A 5-bit code N is expanded to a 32-bit thermometer word with the N least significant bits set. An internal sweep sequencer generates ramps of codes, and both direct and ramp words go out on a valid/ready stream. This drives the encoder and the TDC back end as a test pattern source for loop-back and code-density checks.

## Interface
- `BIN_WIDTH`, 5, binary code width
- `THERMO_WIDTH`, 32, thermometer width; must equal 2**BIN_WIDTH
- `DWELL_WIDTH`, 8, width of the sweep dwell counter
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  direct code offered
- `in_ready`  out  1  direct code accepted when high together with in_valid
- `in_bin`  in  BIN_WIDTH  direct binary code
- `sweep_start`  in  1  one-cycle request to start a ramp; sampled only in IDLE
- `sweep_abort`  in  1  ends a running ramp
- `sweep_lo`, `sweep_hi`  in  BIN_WIDTH  ramp bounds, inclusive
- `sweep_dwell`  in  DWELL_WIDTH  idle cycles between ramp words
- `busy`  out  1  high while the FSM is not in IDLE
- `sweep_done`  out  1  one-cycle pulse when a ramp finishes or is aborted
- `out_valid`  out  1  output word valid
- `out_ready`  in  1  consumer accepts
- `out_thermo`  out  THERMO_WIDTH  thermometer word
- `out_bin`  out  BIN_WIDTH  binary code that produced out_thermo

## Operation
- **Decode rule:** `out_thermo[i] = (i < code)`.
  - Code 0 gives all zeros. Code 31 gives 0x7FFF_FFFF.
  - `out_thermo[31]` is always 0. The all-ones word cannot be produced.
  - Feeding the word back to the encoder returns the same code.
- **Output register:** one entry.
  - The entry is free when `!out_valid || out_ready`.
  - It loads only when free.
  - While `out_valid && !out_ready`, `out_thermo` and `out_bin` hold stable.
- **FSM states:** IDLE, EMIT, DWELL.
- **IDLE:**
  - `in_ready` = entry free.
  - On `in_valid && in_ready`, load `in_bin`.
  - If `sweep_start` is high, latch lo, hi and dwell, set `cur = sweep_lo`, and go to EMIT. `in_ready` is forced low that cycle.
  - `sweep_start` wins over a simultaneous `in_valid`.
- **EMIT:**
  - `in_ready` = 0.
  - When the entry is free, load `cur` and set `dcnt = dwell`.
  - If `dwell == 0`, apply the DWELL exit rule in the same cycle. Otherwise go to DWELL.
- **DWELL:**
  - Decrement `dcnt` each cycle.
  - Exit rule when `dcnt` reaches 0:
    - If `cur == hi`, pulse `sweep_done` and go to IDLE.
    - Otherwise `cur = cur + 1` and go to EMIT.
- **Bound cases:**
  - If `lo > hi`, only `lo` is emitted, then `sweep_done`. There is no wrap-around.
  - If `lo == hi`, exactly one word is emitted.
- **Abort:** `sweep_abort` in EMIT or DWELL goes to IDLE and pulses `sweep_done`.
  - A word already in the output register stays valid until consumed.
  - If abort coincides with an EMIT load, the load is suppressed.
- **Input changes:** `sweep_start`, bounds and dwell changes while busy are ignored.

## Timing
- **Reset values:** `out_valid` 0, `out_thermo` 0, `out_bin` 0, `busy` 0, `sweep_done` 0, `in_ready` 0. After reset the FSM is in IDLE with `cur` = 0 and `dcnt` = 0.
- **In-flight data on reset:** an asynchronous reset during a ramp drops the held word immediately.
- **`in_ready` after reset:** goes to 1 on the first clock after deassertion.
- **Direct latency:** accept at edge k gives `out_valid` = 1 after edge k, i.e. 1 cycle.
- **Throughput:** one word per cycle when `out_ready` is held high.
- **Ramp spacing:** with `out_ready` = 1, consecutive ramp words are spaced `dwell + 2` cycles apart.
  - Exception: with `dwell == 0` the spacing is 1 cycle.
- **First ramp word:** valid 2 cycles after the `sweep_start` edge.
- **Done pulse:** `sweep_done` is registered and is asserted the cycle after the FSM decides to return to IDLE.
- **`busy`:** deasserts in the same cycle that `sweep_done` is asserted.

## Structure
- **Shared package (`tdc_pkg`):**
  - `BIN_WIDTH` and `THERMO_WIDTH` constants, shared with the thermometer encoder.
  - FSM state encoding: IDLE = 2'b00, EMIT = 2'b01, DWELL = 2'b10.
- **Sub-module `thermo_expand`:** purely combinational, code to thermometer word, for-loop implementation. It is reused by any later calibration logic.
- **Top level:** FSM, dwell counter, ramp pointer and output register.

## Test plan
- Reset, then `in_bin` = 0, 1, 13, 31 with `out_ready` = 1 -> `out_thermo` = 0x0, 0x1, 0x1FFF, 0x7FFF_FFFF, each 1 cycle after accept.
- Backpressure: load 5, hold `out_ready` = 0 for 4 cycles -> `out_thermo` stays 0x1F, `in_ready` = 0, a second word is not lost and emerges after `out_ready` rises.
- Ramp lo = 3, hi = 6, dwell = 2 -> words 0x7, 0xF, 0x1F, 0x3F spaced 4 cycles apart, then one `sweep_done` pulse and `busy` low.
- Ramp lo = 9, hi = 4 and ramp lo = hi = 0 -> a single word each (0x1FF and 0x0), then `sweep_done`.
- `sweep_abort` during DWELL of the second word of ramp 0..31 -> no further words, `sweep_done` next cycle; `rst_n` low mid-ramp -> all outputs 0 immediately.
- Loop-back: all 32 codes through `thermometer_decoder` into the encoder -> `bin` equals the input code for each.

Source files
------------

// File: rtl/tdc_pkg.sv
// Shared TDC datapath constants and types.
// Used by the thermometer decoder and encoder.
package tdc_pkg;

  localparam int BIN_WIDTH    = 5;
  localparam int THERMO_WIDTH = 32;
  localparam int DWELL_WIDTH  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    EMIT  = 2'b01,
    DWELL = 2'b10
  } sweep_state_t;

endpackage

// File: rtl/thermometer_decoder_if.sv
// Direct-code input stream and thermometer output stream.
// The decoder takes the slave side.
interface thermometer_decoder_if #(
  parameter int BIN_WIDTH    = tdc_pkg::BIN_WIDTH,
  parameter int THERMO_WIDTH = tdc_pkg::THERMO_WIDTH
);

  logic                    in_valid;
  logic                    in_ready;
  logic [BIN_WIDTH-1:0]    in_bin;
  logic                    out_valid;
  logic                    out_ready;
  logic [THERMO_WIDTH-1:0] out_thermo;
  logic [BIN_WIDTH-1:0]    out_bin;

  modport master (
    output in_valid,
    output in_bin,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_thermo,
    input  out_bin
  );

  modport slave (
    input  in_valid,
    input  in_bin,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_thermo,
    output out_bin
  );

endinterface

// File: rtl/thermo_expand.sv
// Combinational binary code to thermometer word.
// Bit i is set when i is below the code.
module thermo_expand #(
  parameter int BIN_WIDTH    = 5,
  parameter int THERMO_WIDTH = 32
) (
  input  logic [BIN_WIDTH-1:0]    code,
  output logic [THERMO_WIDTH-1:0] thermo
);

  always_comb begin
    thermo = '0;
    for (int i = 0; i < THERMO_WIDTH; i++) begin
      thermo[i] = (i < int'(code));
    end
  end

endmodule

// File: rtl/thermometer_decoder.sv
// Registered binary-to-thermometer decoder with
// a built-in ramp sequencer for TDC test patterns.
module thermometer_decoder #(
  parameter int BIN_WIDTH    = 5,
  parameter int THERMO_WIDTH = 32,
  parameter int DWELL_WIDTH  = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  thermometer_decoder_if.slave   bus,
  input  logic                   sweep_start,
  input  logic                   sweep_abort,
  input  logic [BIN_WIDTH-1:0]   sweep_lo,
  input  logic [BIN_WIDTH-1:0]   sweep_hi,
  input  logic [DWELL_WIDTH-1:0] sweep_dwell,
  output logic                   busy,
  output logic                   sweep_done
);

  import tdc_pkg::*;

  sweep_state_t state;
  sweep_state_t state_nx;

  logic [BIN_WIDTH-1:0]    cur;
  logic [BIN_WIDTH-1:0]    cur_nx;
  logic [BIN_WIDTH-1:0]    hi_q;
  logic [BIN_WIDTH-1:0]    load_bin;
  logic [BIN_WIDTH-1:0]    bin_q;
  logic [DWELL_WIDTH-1:0]  dcnt;
  logic [DWELL_WIDTH-1:0]  dcnt_nx;
  logic [DWELL_WIDTH-1:0]  dwell_q;
  logic [THERMO_WIDTH-1:0] load_thermo;
  logic [THERMO_WIDTH-1:0] thermo_q;

  logic valid_q;
  logic done_q;
  logic done_nx;
  logic rdy_en;
  logic rdy;
  logic free;
  logic load;
  logic latch;
  logic step;

  assign free = !valid_q || bus.out_ready;

  thermo_expand #(
    .BIN_WIDTH    (BIN_WIDTH),
    .THERMO_WIDTH (THERMO_WIDTH)
  ) u_expand (
    .code   (load_bin),
    .thermo (load_thermo)
  );

  always_comb begin
    state_nx = state;
    cur_nx   = cur;
    dcnt_nx  = dcnt;
    done_nx  = 1'b0;
    rdy      = 1'b0;
    load     = 1'b0;
    load_bin = cur;
    latch    = 1'b0;
    step     = 1'b0;
    unique case (state)
      IDLE: begin
        if (sweep_start) begin
          latch    = 1'b1;
          cur_nx   = sweep_lo;
          state_nx = EMIT;
        end else begin
          rdy      = rdy_en && free;
          load     = rdy && bus.in_valid;
          load_bin = bus.in_bin;
        end
      end
      EMIT: begin
        if (sweep_abort) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end else if (free) begin
          load    = 1'b1;
          dcnt_nx = dwell_q;
          if (dwell_q == '0) begin
            step = 1'b1;
          end else begin
            state_nx = DWELL;
          end
        end
      end
      DWELL: begin
        if (sweep_abort) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end else if (dcnt == '0) begin
          step = 1'b1;
        end else begin
          dcnt_nx = dcnt - DWELL_WIDTH'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
    // ">=" also ends a ramp whose lo exceeds hi
    if (step) begin
      if (cur >= hi_q) begin
        state_nx = IDLE;
        done_nx  = 1'b1;
      end else begin
        cur_nx   = cur + BIN_WIDTH'(1);
        state_nx = EMIT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cur     <= '0;
      dcnt    <= '0;
      hi_q    <= '0;
      dwell_q <= '0;
      done_q  <= 1'b0;
      rdy_en  <= 1'b0;
    end else begin
      state  <= state_nx;
      cur    <= cur_nx;
      dcnt   <= dcnt_nx;
      done_q <= done_nx;
      rdy_en <= 1'b1;
      if (latch) begin
        hi_q    <= sweep_hi;
        dwell_q <= sweep_dwell;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      thermo_q <= '0;
      bin_q    <= '0;
    end else if (load) begin
      valid_q  <= 1'b1;
      thermo_q <= load_thermo;
      bin_q    <= load_bin;
    end else if (bus.out_ready) begin
      valid_q  <= 1'b0;
    end
  end

  assign bus.in_ready   = rdy;
  assign bus.out_valid  = valid_q;
  assign bus.out_thermo = thermo_q;
  assign bus.out_bin    = bin_q;
  assign busy           = (state != IDLE);
  assign sweep_done     = done_q;

endmodule

// File: tb/tb_thermometer_decoder.sv
// Scoreboard bench for thermometer_decoder:
// direct codes, backpressure, ramps, abort, reset.
module tb_thermometer_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       sweep_start = 1'b0;
  logic       sweep_abort = 1'b0;
  logic [4:0] sweep_lo = '0;
  logic [4:0] sweep_hi = '0;
  logic [7:0] sweep_dwell = '0;
  logic       busy;
  logic       sweep_done;

  thermometer_decoder_if bus ();

  thermometer_decoder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .sweep_start (sweep_start),
    .sweep_abort (sweep_abort),
    .sweep_lo    (sweep_lo),
    .sweep_hi    (sweep_hi),
    .sweep_dwell (sweep_dwell),
    .busy        (busy),
    .sweep_done  (sweep_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int code;
    int at;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  bit   seen = 0;
  bit   bp_rand = 0;

  function automatic logic [31:0] thermo_of(int code);
    logic [63:0] w;
    w = (64'd1 << code) - 64'd1;
    return w[31:0];
  endfunction

  function automatic int encode(logic [31:0] w);
    int n;
    n = 0;
    while (n < 32 && w[n]) n++;
    return n;
  endfunction

  task automatic check(string name, longint act, longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic expect_word(int code, int at);
    exp_t e;
    e.code = code;
    e.at   = at;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.out_valid) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_word: got bin %0d, want none",
                 bus.out_bin);
      end else begin
        if (!seen) begin
          seen = 1;
          if (q[0].at >= 0) check("word_cycle", cyc, q[0].at);
        end
        check("out_bin", bus.out_bin, q[0].code);
        check("out_thermo", bus.out_thermo, thermo_of(q[0].code));
        check("loopback", encode(bus.out_thermo), q[0].code);
        if (bus.out_ready) begin
          void'(q.pop_front());
          seen = 0;
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (bp_rand) bus.out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(int code);
    bit acc;
    acc = 0;
    bus.in_valid = 1'b1;
    bus.in_bin   = 5'(code);
    for (int k = 0; k < 200 && !acc; k++) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
    end
    if (acc) begin
      expect_word(code, cyc);
    end else begin
      tests++;
      fails++;
      $display("FAIL send_timeout: got no accept, want accept of %0d",
               code);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(int exp_cyc);
    bit got;
    got = 0;
    for (int k = 0; k < 400 && !got; k++) begin
      @(negedge clk);
      got = sweep_done;
    end
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: got no sweep_done, want one");
    end else begin
      check("done_cycle", cyc, exp_cyc);
      check("busy_at_done", busy, 0);
      @(negedge clk);
      check("done_pulse_width", sweep_done, 0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic ramp(int lo, int hi, int dw, bit with_direct);
    int c;
    int n;
    int sp;
    c           = cyc;
    sweep_lo    = 5'(lo);
    sweep_hi    = 5'(hi);
    sweep_dwell = 8'(dw);
    sweep_start = 1'b1;
    n  = (lo > hi) ? 1 : hi - lo + 1;
    sp = (dw == 0) ? 1 : dw + 2;
    for (int i = 0; i < n; i++) expect_word(lo + i, c + 2 + i * sp);
    if (with_direct) begin
      bus.in_valid = 1'b1;
      bus.in_bin   = 5'd20;
      @(negedge clk);
      check("start_blocks_in_ready", bus.in_ready, 0);
    end
    @(posedge clk);
    #1;
    sweep_start  = 1'b0;
    bus.in_valid = 1'b0;
    check("busy_in_ramp", busy, 1);
    wait_done(c + 2 + (n - 1) * sp + ((dw == 0) ? 0 : dw + 1));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1);
  end

  initial begin
    int c;
    bus.in_valid  = 1'b0;
    bus.in_bin    = '0;
    bus.out_ready = 1'b1;

    #1 rst_n = 1'b0;
    #2;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_thermo", bus.out_thermo, 0);
    check("rst_out_bin", bus.out_bin, 0);
    check("rst_busy", busy, 0);
    check("rst_sweep_done", sweep_done, 0);
    check("rst_in_ready", bus.in_ready, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    #1 check("in_ready_before_clock", bus.in_ready, 0);
    @(posedge clk);
    #1 check("in_ready_after_clock", bus.in_ready, 1);

    send(0);
    send(1);
    send(13);
    send(31);
    idle(2);

    bus.out_ready = 1'b0;
    send(5);
    bus.in_valid = 1'b1;
    bus.in_bin   = 5'd7;
    repeat (4) begin
      @(negedge clk);
      check("bp_in_ready", bus.in_ready, 0);
      check("bp_hold_thermo", bus.out_thermo, 32'h1F);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    send(7);
    idle(2);

    bp_rand = 1;
    repeat (40) send($urandom_range(0, 31));
    bp_rand = 0;
    bus.out_ready = 1'b1;
    idle(3);

    ramp(3, 6, 2, 0);
    ramp(9, 4, 3, 0);
    ramp(0, 0, 0, 0);
    ramp(2, 2, 1, 1);
    ramp(10, 20, 0, 0);
    repeat (4) begin
      ramp($urandom_range(0, 31), $urandom_range(0, 31),
           $urandom_range(0, 4), 0);
    end

    c           = cyc;
    sweep_lo    = 5'd0;
    sweep_hi    = 5'd31;
    sweep_dwell = 8'd3;
    sweep_start = 1'b1;
    expect_word(0, c + 2);
    expect_word(1, c + 7);
    @(posedge clk);
    #1 sweep_start = 1'b0;
    while (cyc < c + 8) begin
      @(posedge clk);
      #1;
    end
    sweep_abort = 1'b1;
    @(posedge clk);
    #1 sweep_abort = 1'b0;
    wait_done(c + 9);
    idle(10);
    check("busy_after_abort", busy, 0);

    bus.out_ready = 1'b0;
    c           = cyc;
    sweep_lo    = 5'd4;
    sweep_hi    = 5'd31;
    sweep_dwell = 8'd2;
    sweep_start = 1'b1;
    expect_word(4, c + 2);
    @(posedge clk);
    #1 sweep_start = 1'b0;
    while (cyc < c + 5) begin
      @(posedge clk);
      #1;
    end
    check("held_before_reset", bus.out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_out_thermo", bus.out_thermo, 0);
    check("mid_rst_out_bin", bus.out_bin, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_sweep_done", sweep_done, 0);
    check("mid_rst_in_ready", bus.in_ready, 0);
    q.delete();
    seen = 0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 check("in_ready_after_rerst", bus.in_ready, 1);

    for (int i = 0; i < 32; i++) send(i);
    idle(4);
    check("queue_drained", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
